// File: rtl/corner_pkg.sv
// Shared definitions for the corner packer: word layout, markers and FSM encoding.
package corner_pkg;

  localparam int unsigned CORNER_W = 32;
  localparam int unsigned LANES    = 4;
  localparam int unsigned WORD_W   = CORNER_W * LANES;

  localparam logic [CORNER_W-1:0] TRAILER_MARK = 32'hFFFF_FFFF;
  localparam logic [CORNER_W-1:0] PAD_WORD     = 32'h0;

  // Corner word: {cam, 2'b0, col[10:0], row[9:0], score[7:0]}
  localparam int unsigned SCORE_LSB = 0;
  localparam int unsigned SCORE_W   = 8;
  localparam int unsigned ROW_LSB   = 8;
  localparam int unsigned ROW_W     = 10;
  localparam int unsigned COL_LSB   = 18;
  localparam int unsigned COL_W     = 11;
  localparam int unsigned CAM_LSB   = 31;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RUN   = 3'd1,
    DRAIN = 3'd2,
    PAD   = 3'd3,
    TRAIL = 3'd4
  } state_e;

  function automatic logic [SCORE_W-1:0] corner_score(input logic [CORNER_W-1:0] w);
    return w[SCORE_LSB +: SCORE_W];
  endfunction

  function automatic logic [ROW_W-1:0] corner_row(input logic [CORNER_W-1:0] w);
    return w[ROW_LSB +: ROW_W];
  endfunction

  function automatic logic [COL_W-1:0] corner_col(input logic [CORNER_W-1:0] w);
    return w[COL_LSB +: COL_W];
  endfunction

  function automatic logic corner_cam(input logic [CORNER_W-1:0] w);
    return w[CAM_LSB];
  endfunction

  // Left-justify the n newest corners of acc (newest in the low lane) and zero-fill the rest.
  function automatic logic [WORD_W-1:0] pad_lanes(input logic [3*CORNER_W-1:0] acc,
                                                  input logic [1:0]            n);
    case (n)
      2'd1:    return {acc[31:0], PAD_WORD, PAD_WORD, PAD_WORD};
      2'd2:    return {acc[63:0], PAD_WORD, PAD_WORD};
      2'd3:    return {acc[95:0], PAD_WORD};
      default: return {PAD_WORD, PAD_WORD, PAD_WORD, PAD_WORD};
    endcase
  endfunction

  function automatic logic [WORD_W-1:0] trailer_word(input logic [15:0] frame,
                                                     input logic [31:0] cnt);
    return {TRAILER_MARK, 16'h0, frame, 32'h0, cnt};
  endfunction

endpackage

// File: rtl/pack_fifo.sv
// Synchronous show-ahead FIFO; a write while full succeeds only alongside a read.
module pack_fifo #(
  parameter  int unsigned DEPTH = 16,
  parameter  int unsigned WIDTH = 128,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             wr_ok, rd_ok;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rd_data = empty ? '0 : mem_q[rd_ptr_q];

  assign rd_ok = rd_en & ~empty;
  assign wr_ok = wr_en & (~full | rd_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + (AW+1)'(wr_ok) - (AW+1)'(rd_ok);
    if (wr_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (rd_ok) rd_ptr_d = rd_ptr_q + AW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; rd_data is gated to zero while empty.
  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/corner_packer.sv
// Packs 32-bit corner words four per 128-bit FIFO entry, closing each frame with
// an optional zero-padded word and a trailer carrying frame number and corner count.
module corner_packer
  import corner_pkg::*;
#(
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned FLUSH_DLY = 32
) (
  input  logic                c,
  input  logic                rst,
  input  logic                en,
  input  logic [CORNER_W-1:0] d,
  input  logic                dv,
  input  logic                fv,
  output logic [WORD_W-1:0]   q,
  output logic                qv,
  input  logic                q_rdy,
  output logic                overflow
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned LW = CW + 1;
  localparam int unsigned TW = $clog2(FLUSH_DLY + 1);

  state_e                  state_q, state_d;
  logic [3*CORNER_W-1:0]   acc_q, acc_d;
  logic [1:0]              lane_q, lane_d;
  logic [31:0]             cnt_q, cnt_d;
  logic [15:0]             frame_q, frame_d;
  logic [TW-1:0]           timer_q, timer_d;
  logic                    ovf_q, ovf_d;
  logic                    fv_q;
  logic                    push_q, push_d;
  logic [WORD_W-1:0]       push_data_q, push_data_d;

  logic                    fifo_full, fifo_empty;
  logic [CW-1:0]           fifo_count;
  logic [LW-1:0]           level;
  logic                    fv_rise, fv_fall, pop, fifo_room, capture, accept, drop;

  pack_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (WORD_W)
  ) u_fifo (
    .clk     (c),
    .rst     (rst),
    .wr_en   (push_q),
    .wr_data (push_data_q),
    .rd_en   (q_rdy),
    .rd_data (q),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign qv       = ~fifo_empty;
  assign overflow = ovf_q;
  assign fv_rise  = fv & ~fv_q;
  assign fv_fall  = ~fv & fv_q;
  assign pop      = qv & q_rdy;

  // Occupancy one cycle ahead, counting the word still in the push register.
  assign level     = LW'(fifo_count) + LW'(push_q) - LW'(pop);
  assign fifo_room = push_q ? (level < LW'(DEPTH)) : (~fifo_full | pop);

  assign capture = en & dv & ((state_q == RUN) | (state_q == DRAIN));
  assign accept  = capture & fifo_room;
  assign drop    = capture & ~fifo_room;

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    lane_d      = lane_q;
    cnt_d       = cnt_q;
    frame_d     = frame_q;
    timer_d     = timer_q;
    ovf_d       = ovf_q | drop;
    push_d      = 1'b0;
    push_data_d = push_data_q;

    if (accept) begin
      acc_d  = {acc_q[2*CORNER_W-1:0], d};
      lane_d = lane_q + 2'd1;
      cnt_d  = cnt_q + 32'd1;
      if (lane_q == 2'd3) begin
        push_d      = 1'b1;
        push_data_d = {acc_q, d};
      end
    end

    case (state_q)
      IDLE: begin
        if (fv_rise) begin
          state_d = RUN;
          cnt_d   = '0;
          lane_d  = '0;
          ovf_d   = 1'b0;
        end
      end
      RUN: begin
        if (fv_fall) begin
          state_d = DRAIN;
          timer_d = '0;
        end
      end
      DRAIN: begin
        timer_d = timer_q + TW'(1);
        // lane_d includes a corner accepted on this final cycle.
        if (timer_q == TW'(FLUSH_DLY - 1)) state_d = (lane_d != 2'd0) ? PAD : TRAIL;
      end
      PAD: begin
        if (fifo_room) begin
          push_d      = 1'b1;
          push_data_d = pad_lanes(acc_q, lane_q);
          lane_d      = '0;
          state_d     = TRAIL;
        end
      end
      TRAIL: begin
        if (fifo_room) begin
          push_d      = 1'b1;
          push_data_d = trailer_word(frame_q, cnt_q);
          frame_d     = frame_q + 16'd1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // fv_q tracks fv through reset so a frame already in progress is not seen as a new edge.
  always_ff @(posedge c) begin
    fv_q <= fv;
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      lane_q      <= '0;
      cnt_q       <= '0;
      frame_q     <= '0;
      timer_q     <= '0;
      ovf_q       <= 1'b0;
      push_q      <= 1'b0;
      push_data_q <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      lane_q      <= lane_d;
      cnt_q       <= cnt_d;
      frame_q     <= frame_d;
      timer_q     <= timer_d;
      ovf_q       <= ovf_d;
      push_q      <= push_d;
      push_data_q <= push_data_d;
    end
  end

endmodule
